wb_scoreboard: RTL and testbench

Register scoreboard and write-back arbiter between the decode stage and the register file. Tracks which architectural registers have a result in flight, holds back decode on RAW/WAW hazards, and shares the single regfile write port between the ALU and load/store write-back sources using round-robin arbitration. Sits beside `id_stage`: decode offers each instruction here before reading operands, and all regfile writes pass through this block.

---
 rtl/wb_scoreboard.sv | 150 +++++++++++++++
 tb/tb_wb_scoreboard.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_scoreboard.sv
// Register scoreboard and round-robin write-back arbiter in front of the regfile write port.
// Optional macro WB_SB_BYPASS_EN: forward the registered write-back to decode in the cycle it is written.
module wb_scoreboard #(
    parameter int DATA_WIDTH = 64,
    parameter int MAX_OUT    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iss_valid,
    output logic                  iss_ready,
    input  logic                  iss_rs1_ena,
    input  logic                  iss_rs2_ena,
    input  logic [4:0]            iss_rs1_addr,
    input  logic [4:0]            iss_rs2_addr,
    input  logic                  iss_rd_ena,
    input  logic [4:0]            iss_rd_addr,
    input  logic                  alu_wb_valid,
    output logic                  alu_wb_ready,
    input  logic [4:0]            alu_wb_addr,
    input  logic [DATA_WIDTH-1:0] alu_wb_data,
    input  logic                  lsu_wb_valid,
    output logic                  lsu_wb_ready,
    input  logic [4:0]            lsu_wb_addr,
    input  logic [DATA_WIDTH-1:0] lsu_wb_data,
    output logic                  rf_w_ena,
    output logic [4:0]            rf_w_addr,
    output logic [DATA_WIDTH-1:0] rf_w_data,
    output logic                  fwd_rs1_hit,
    output logic                  fwd_rs2_hit,
    output logic [DATA_WIDTH-1:0] fwd_data,
    output logic [5:0]            out_cnt,
    output logic                  idle,
    output logic                  sb_err
);

    localparam logic [5:0] MAX_CNT = 6'(MAX_OUT);

    logic [31:0]           busy_q, busy_d;
    logic [5:0]            out_cnt_q, out_cnt_d;
    logic                  rr_ptr_q, rr_ptr_d;
    logic                  rf_w_ena_q, rf_w_ena_d;
    logic [4:0]            rf_w_addr_q, rf_w_addr_d;
    logic [DATA_WIDTH-1:0] rf_w_data_q, rf_w_data_d;
    logic                  sb_err_q, sb_err_d;

    logic                  rs1_fwd, rs2_fwd, rd_fwd;
    logic                  hz, full, rd_live, iss_inc, clr_dec;
    logic                  alu_grant, lsu_grant, wb_grant;
    logic [4:0]            wb_addr;
    logic [DATA_WIDTH-1:0] wb_data;

    // rf_w_ena_q already implies a nonzero address, so x0 sources never match.
`ifdef WB_SB_BYPASS_EN
    assign rs1_fwd     = rf_w_ena_q & (rf_w_addr_q == iss_rs1_addr);
    assign rs2_fwd     = rf_w_ena_q & (rf_w_addr_q == iss_rs2_addr);
    assign rd_fwd      = rf_w_ena_q & (rf_w_addr_q == iss_rd_addr);
    assign fwd_rs1_hit = iss_rs1_ena & rs1_fwd;
    assign fwd_rs2_hit = iss_rs2_ena & rs2_fwd;
    assign fwd_data    = rf_w_data_q;
`else
    assign rs1_fwd     = 1'b0;
    assign rs2_fwd     = 1'b0;
    assign rd_fwd      = 1'b0;
    assign fwd_rs1_hit = 1'b0;
    assign fwd_rs2_hit = 1'b0;
    assign fwd_data    = '0;
`endif

    always_comb begin
        rd_live   = iss_rd_ena & (iss_rd_addr != 5'd0);
        hz        = (iss_rs1_ena & busy_q[iss_rs1_addr] & ~rs1_fwd)
                  | (iss_rs2_ena & busy_q[iss_rs2_addr] & ~rs2_fwd)
                  | (iss_rd_ena  & busy_q[iss_rd_addr]  & ~rd_fwd);
        full      = rd_live & (out_cnt_q == MAX_CNT);
        iss_ready = ~hz & ~full;
        iss_inc   = iss_valid & iss_ready & rd_live;
    end

    always_comb begin
        alu_wb_ready = ~lsu_wb_valid | ~rr_ptr_q;
        lsu_wb_ready = ~alu_wb_valid | rr_ptr_q;
        alu_grant    = alu_wb_valid & alu_wb_ready;
        lsu_grant    = lsu_wb_valid & lsu_wb_ready;
        wb_grant     = alu_grant | lsu_grant;
        wb_addr      = alu_grant ? alu_wb_addr : lsu_wb_addr;
        wb_data      = alu_grant ? alu_wb_data : lsu_wb_data;
    end

    always_comb begin
        busy_d      = busy_q;
        out_cnt_d   = out_cnt_q;
        sb_err_d    = sb_err_q;
        rr_ptr_d    = rr_ptr_q;
        rf_w_ena_d  = wb_grant & (wb_addr != 5'd0);
        rf_w_addr_d = wb_grant ? wb_addr : rf_w_addr_q;
        rf_w_data_d = wb_grant ? wb_data : rf_w_data_q;
        clr_dec     = rf_w_ena_q & busy_q[rf_w_addr_q];

        if (rf_w_ena_q) begin
            busy_d[rf_w_addr_q] = 1'b0;
            if (!busy_q[rf_w_addr_q]) begin
                sb_err_d = 1'b1;
            end
        end
        // Applied after the clear so a same-cycle reissue keeps the register busy.
        if (iss_inc) begin
            busy_d[iss_rd_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;

        case ({iss_inc, clr_dec})
            2'b10:   out_cnt_d = out_cnt_q + 6'd1;
            2'b01:   out_cnt_d = out_cnt_q - 6'd1;
            default: out_cnt_d = out_cnt_q;
        endcase

        // Pointer moves to the losing source only under contention.
        if (alu_wb_valid && lsu_wb_valid) begin
            rr_ptr_d = ~rr_ptr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q      <= '0;
            out_cnt_q   <= '0;
            rr_ptr_q    <= 1'b0;
            rf_w_ena_q  <= 1'b0;
            rf_w_addr_q <= '0;
            rf_w_data_q <= '0;
            sb_err_q    <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            out_cnt_q   <= out_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            rf_w_ena_q  <= rf_w_ena_d;
            rf_w_addr_q <= rf_w_addr_d;
            rf_w_data_q <= rf_w_data_d;
            sb_err_q    <= sb_err_d;
        end
    end

    assign rf_w_ena  = rf_w_ena_q;
    assign rf_w_addr = rf_w_addr_q;
    assign rf_w_data = rf_w_data_q;
    assign out_cnt   = out_cnt_q;
    assign sb_err    = sb_err_q;
    assign idle      = (out_cnt_q == 6'd0) & ~alu_wb_valid & ~lsu_wb_valid;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Scoreboard bench for wb_scoreboard: directed scenarios plus randomized issue/write-back traffic.
module tb_wb_scoreboard;
    localparam int DW = 64;
    localparam int MO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          iss_valid, iss_ready, iss_rs1_ena, iss_rs2_ena, iss_rd_ena;
    logic [4:0]    iss_rs1_addr, iss_rs2_addr, iss_rd_addr;
    logic          alu_wb_valid, alu_wb_ready, lsu_wb_valid, lsu_wb_ready;
    logic [4:0]    alu_wb_addr, lsu_wb_addr;
    logic [DW-1:0] alu_wb_data, lsu_wb_data;
    logic          rf_w_ena;
    logic [4:0]    rf_w_addr;
    logic [DW-1:0] rf_w_data;
    logic          fwd_rs1_hit, fwd_rs2_hit;
    logic [DW-1:0] fwd_data;
    logic [5:0]    out_cnt;
    logic          idle, sb_err;

    wb_scoreboard #(.DATA_WIDTH(DW), .MAX_OUT(MO)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_rs1_ena(iss_rs1_ena), .iss_rs2_ena(iss_rs2_ena),
        .iss_rs1_addr(iss_rs1_addr), .iss_rs2_addr(iss_rs2_addr),
        .iss_rd_ena(iss_rd_ena), .iss_rd_addr(iss_rd_addr),
        .alu_wb_valid(alu_wb_valid), .alu_wb_ready(alu_wb_ready),
        .alu_wb_addr(alu_wb_addr), .alu_wb_data(alu_wb_data),
        .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready),
        .lsu_wb_addr(lsu_wb_addr), .lsu_wb_data(lsu_wb_data),
        .rf_w_ena(rf_w_ena), .rf_w_addr(rf_w_addr), .rf_w_data(rf_w_data),
        .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs2_hit(fwd_rs2_hit), .fwd_data(fwd_data),
        .out_cnt(out_cnt), .idle(idle), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [4:0]    addr;
        logic [DW-1:0] data;
    } wb_t;
    wb_t exp_q[$];

    // Reference model: set of in-flight registers, counter, sticky error, arbiter turn,
    // and the write-back currently presented to the regfile.
    bit            m_busy [32];
    int            m_cnt;
    bit            m_err;
    bit            m_rr;
    bit            m_pv;
    logic [4:0]    m_pa;
    logic [DW-1:0] m_pd;
    bit            last_fire, last_ag, last_lg;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chkv(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void m_reset();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_cnt = 0;
        m_err = 1'b0;
        m_rr  = 1'b0;
        m_pv  = 1'b0;
        m_pa  = '0;
        m_pd  = '0;
        exp_q.delete();
    endfunction

    function automatic bit m_src_hz(input logic ena, input logic [4:0] a);
        if (!ena || a == 5'd0) return 1'b0;
`ifdef WB_SB_BYPASS_EN
        if (m_pv && m_pa == a) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    always @(negedge clk) begin : monitor
        wb_t e;
        if (!rst && rf_w_ena === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wb_unexpected: got write to x%0d, expected none", rf_w_addr);
            end else begin
                e = exp_q.pop_front();
                chkv("wb_addr", 64'(rf_w_addr), 64'(e.addr));
                chkv("wb_data", rf_w_data, e.data);
            end
        end
    end

    task automatic idle_inputs();
        iss_valid = 0; iss_rs1_ena = 0; iss_rs2_ena = 0; iss_rd_ena = 0;
        iss_rs1_addr = 0; iss_rs2_addr = 0; iss_rd_addr = 0;
        alu_wb_valid = 0; alu_wb_addr = 0; alu_wb_data = 0;
        lsu_wb_valid = 0; lsu_wb_addr = 0; lsu_wb_data = 0;
    endtask

    task automatic set_iss(input logic v, input logic e1, input logic [4:0] a1,
                           input logic e2, input logic [4:0] a2,
                           input logic ed, input logic [4:0] d);
        iss_valid = v; iss_rs1_ena = e1; iss_rs1_addr = a1;
        iss_rs2_ena = e2; iss_rs2_addr = a2; iss_rd_ena = ed; iss_rd_addr = d;
    endtask

    task automatic alu_req(input logic v, input logic [4:0] a, input logic [DW-1:0] d);
        alu_wb_valid = v; alu_wb_addr = a; alu_wb_data = d;
    endtask

    task automatic lsu_req(input logic v, input logic [4:0] a, input logic [DW-1:0] d);
        lsu_wb_valid = v; lsu_wb_addr = a; lsu_wb_data = d;
    endtask

    // Called just after a rising edge with this cycle's inputs applied.
    task automatic step();
        bit  hz, rdy, both, ag, lg, hit1, hit2;
        wb_t e;
        #1;
        hz   = m_src_hz(iss_rs1_ena, iss_rs1_addr) | m_src_hz(iss_rs2_ena, iss_rs2_addr)
             | m_src_hz(iss_rd_ena, iss_rd_addr);
        rdy  = !hz && !(iss_rd_ena && iss_rd_addr != 0 && m_cnt == MO);
        both = alu_wb_valid && lsu_wb_valid;
        ag   = alu_wb_valid && (!both || !m_rr);
        lg   = lsu_wb_valid && (!both || m_rr);
`ifdef WB_SB_BYPASS_EN
        hit1 = iss_rs1_ena && m_pv && m_pa == iss_rs1_addr;
        hit2 = iss_rs2_ena && m_pv && m_pa == iss_rs2_addr;
        if (m_pv) chkv("fwd_data", fwd_data, m_pd);
`else
        hit1 = 1'b0;
        hit2 = 1'b0;
        chkv("fwd_data", fwd_data, 64'd0);
`endif
        chk1("iss_ready", iss_ready, rdy);
        chk1("alu_wb_ready", alu_wb_ready, !lsu_wb_valid || !m_rr);
        chk1("lsu_wb_ready", lsu_wb_ready, !alu_wb_valid || m_rr);
        chk1("fwd_rs1_hit", fwd_rs1_hit, hit1);
        chk1("fwd_rs2_hit", fwd_rs2_hit, hit2);
        chkv("out_cnt", 64'(out_cnt), 64'(m_cnt));
        chk1("sb_err", sb_err, m_err);
        chk1("idle", idle, m_cnt == 0 && !alu_wb_valid && !lsu_wb_valid);
        chk1("rf_w_ena", rf_w_ena, m_pv);

        last_fire = iss_valid && rdy;
        last_ag   = ag;
        last_lg   = lg;
        if (m_pv) begin
            if (m_busy[m_pa]) begin
                m_busy[m_pa] = 1'b0;
                m_cnt--;
            end else begin
                m_err = 1'b1;
            end
        end
        if (last_fire && iss_rd_ena && iss_rd_addr != 0) begin
            m_busy[iss_rd_addr] = 1'b1;
            m_cnt++;
        end
        if (both) m_rr = !m_rr;
        m_pv = 1'b0;
        if (ag || lg) begin
            m_pa = ag ? alu_wb_addr : lsu_wb_addr;
            m_pd = ag ? alu_wb_data : lsu_wb_data;
            m_pv = (m_pa != 0);
            if (m_pv) begin
                e.addr = m_pa;
                e.data = m_pd;
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int  q_inf[$];
        bit  ap, lp, stop_iss;
        idle_inputs();
        rst = 1'b1;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chkv("rst_out_cnt", 64'(out_cnt), 64'd0);
        chk1("rst_rf_w_ena", rf_w_ena, 1'b0);
        chkv("rst_rf_w_addr", 64'(rf_w_addr), 64'd0);
        chkv("rst_rf_w_data", rf_w_data, 64'd0);
        chk1("rst_sb_err", sb_err, 1'b0);
        chk1("rst_iss_ready", iss_ready, 1'b1);
        chk1("rst_alu_ready", alu_wb_ready, 1'b1);
        chk1("rst_lsu_ready", lsu_wb_ready, 1'b1);
        chk1("rst_idle", idle, 1'b1);
        rst = 1'b0;

        // RAW on x5 resolved by an ALU write-back of 0x2A.
        set_iss(1, 0, 0, 0, 0, 1, 5); step();
        set_iss(1, 1, 5, 0, 0, 0, 0);
        #1; chkv("raw_cnt", 64'(out_cnt), 64'd1); chk1("raw_stall", iss_ready, 1'b0);
        step();
        alu_req(1, 5, 64'h2A); step();
        alu_req(0, 0, 0);
        #1;
        chk1("wb_ena_n1", rf_w_ena, 1'b1);
        chkv("wb_addr_n1", 64'(rf_w_addr), 64'd5);
        chkv("wb_data_n1", rf_w_data, 64'h2A);
`ifdef WB_SB_BYPASS_EN
        chk1("byp_ready_n1", iss_ready, 1'b1);
        chk1("byp_hit_n1", fwd_rs1_hit, 1'b1);
        chkv("byp_data_n1", fwd_data, 64'h2A);
`else
        chk1("nobyp_stall_n1", iss_ready, 1'b0);
`endif
        step();
        #1; chk1("raw_ready_n2", iss_ready, 1'b1);
        step();
        idle_inputs(); step();

        // Round-robin under contention: ALU, LSU, ALU, LSU.
        for (int r = 10; r <= 14; r++) begin
            set_iss(1, 0, 0, 0, 0, 1, 5'(r)); step();
        end
        idle_inputs();
        alu_req(1, 10, 64'hA10); lsu_req(1, 11, 64'hB11);
        #1; chk1("rr0_alu", alu_wb_ready, 1'b1); chk1("rr0_lsu", lsu_wb_ready, 1'b0);
        step();
        alu_req(1, 12, 64'hA12);
        #1; chk1("rr1_alu", alu_wb_ready, 1'b0); chk1("rr1_lsu", lsu_wb_ready, 1'b1);
        step();
        lsu_req(1, 13, 64'hB13);
        #1; chk1("rr2_alu", alu_wb_ready, 1'b1); chk1("rr2_lsu", lsu_wb_ready, 1'b0);
        step();
        alu_req(1, 14, 64'hA14);
        #1; chk1("rr3_alu", alu_wb_ready, 1'b0); chk1("rr3_lsu", lsu_wb_ready, 1'b1);
        step();
        lsu_req(0, 0, 0); step();
        alu_req(0, 0, 0); step(); step();

        // Fill to MAX_OUT, then one write-back releases the stall.
        for (int r = 1; r <= 8; r++) begin
            set_iss(1, 0, 0, 0, 0, 1, 5'(r)); step();
        end
        set_iss(1, 0, 0, 0, 0, 1, 9);
        #1; chkv("full_cnt", 64'(out_cnt), 64'd8); chk1("full_stall", iss_ready, 1'b0);
        step();
        alu_req(1, 1, 64'h1111); step();
        alu_req(0, 0, 0); step();
        #1; chk1("full_release", iss_ready, 1'b1);
        step();
        set_iss(0, 0, 0, 0, 0, 0, 0);
        for (int r = 2; r <= 9; r++) begin
            alu_req(1, 5'(r), 64'(r) * 64'h0101); step();
        end
        alu_req(0, 0, 0); step(); step();

        // Write-back to x0 is silent; to non-busy x7 raises the sticky error.
        alu_req(1, 0, 64'hDEAD); step();
        alu_req(0, 0, 0);
        #1; chk1("x0_no_write", rf_w_ena, 1'b0);
        step();
        lsu_req(1, 7, 64'h77); step();
        lsu_req(0, 0, 0);
        #1; chk1("x7_write", rf_w_ena, 1'b1); chkv("x7_addr", 64'(rf_w_addr), 64'd7);
        step();
        #1; chk1("x7_sb_err", sb_err, 1'b1); chkv("x7_cnt", 64'(out_cnt), 64'd0);
        step(); step();

        // Reissue x3 against its own write-back.
        set_iss(1, 0, 0, 0, 0, 1, 3); step();
        set_iss(0, 0, 0, 0, 0, 0, 0);
        alu_req(1, 3, 64'h33); step();
        alu_req(0, 0, 0);
        set_iss(1, 0, 0, 0, 0, 1, 3);
`ifdef WB_SB_BYPASS_EN
        #1; chk1("waw_byp_ready", iss_ready, 1'b1);
`endif
        last_fire = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (last_fire) break;
        end
        chk1("rd3_issued", last_fire, 1'b1);
        set_iss(0, 0, 0, 0, 0, 1, 3);
        #1; chkv("set_wins_cnt", 64'(out_cnt), 64'd1); chk1("set_wins_busy", iss_ready, 1'b0);
        step();
        set_iss(0, 0, 0, 0, 0, 0, 0);
        alu_req(1, 3, 64'h333); step();
        alu_req(0, 0, 0); step(); step();

        // Asynchronous reset with three in flight and a write on the port.
        for (int r = 20; r <= 22; r++) begin
            set_iss(1, 0, 0, 0, 0, 1, 5'(r)); step();
        end
        set_iss(0, 0, 0, 0, 0, 0, 0);
        alu_req(1, 20, 64'h2020); step();
        alu_req(0, 0, 0);
        set_iss(0, 1, 21, 0, 0, 0, 0);
        #1; chk1("pre_rst_wena", rf_w_ena, 1'b1);
        rst = 1'b1;
        #1;
        chkv("rst_mid_cnt", 64'(out_cnt), 64'd0);
        chk1("rst_mid_wena", rf_w_ena, 1'b0);
        chk1("rst_mid_busy", iss_ready, 1'b1);
        m_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        lsu_req(1, 21, 64'h2121); step();
        lsu_req(0, 0, 0); step();
        #1; chk1("late_wb_err", sb_err, 1'b1);
        step();

        rst = 1'b1;
        #1;
        m_reset();
        idle_inputs();
        @(posedge clk); #1;
        rst = 1'b0;

        // Randomized traffic; each source holds its request until granted.
        ap = 0; lp = 0;
        for (int c = 0; c < 900; c++) begin
            stop_iss = (c >= 500);
            if (stop_iss && q_inf.size() == 0 && !ap && !lp) break;
            if (!ap && q_inf.size() > 0 && (stop_iss || $urandom_range(0, 1) == 1)) begin
                ap = 1;
                alu_wb_addr = 5'(q_inf.pop_front());
                alu_wb_data = {$urandom, $urandom};
            end
            if (!lp && q_inf.size() > 0 && (stop_iss || $urandom_range(0, 1) == 1)) begin
                lp = 1;
                lsu_wb_addr = 5'(q_inf.pop_front());
                lsu_wb_data = {$urandom, $urandom};
            end
            alu_wb_valid = ap;
            lsu_wb_valid = lp;
            iss_valid    = !stop_iss && ($urandom_range(0, 3) != 0);
            iss_rs1_ena  = ($urandom_range(0, 1) == 1);
            iss_rs2_ena  = ($urandom_range(0, 1) == 1);
            iss_rd_ena   = ($urandom_range(0, 3) != 0);
            iss_rs1_addr = 5'($urandom_range(0, 15));
            iss_rs2_addr = 5'($urandom_range(0, 15));
            iss_rd_addr  = 5'($urandom_range(0, 15));
            step();
            if (last_fire && iss_rd_ena && iss_rd_addr != 0) q_inf.push_back(int'(iss_rd_addr));
            if (last_ag) ap = 0;
            if (last_lg) lp = 0;
        end
        chk1("drain_done", q_inf.size() == 0 && !ap && !lp, 1'b1);
        idle_inputs();
        step(); step();
        chkv("final_cnt", 64'(out_cnt), 64'd0);
        chk1("final_idle", idle, 1'b1);
        chk1("final_err", sb_err, 1'b0);
        chkv("final_queue", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
